// File: rtl/warp_pkg.sv
// Shared types for the warp mask stack: divergence-stack entry layout and redirect causes.
// Entry field widths follow WARP_LANES / WARP_PC_W; the top-level NUM_LANES / PC_WIDTH must match them.
package warp_pkg;

    localparam int WARP_LANES = 8;
    localparam int WARP_PC_W  = 16;

    typedef struct packed {
        logic [WARP_PC_W-1:0]  rpc;
        logic [WARP_PC_W-1:0]  else_pc;
        logic [WARP_LANES-1:0] else_mask;
        logic [WARP_LANES-1:0] orig_mask;
        logic                  phase;
    } warp_stack_entry_t;

    localparam int WARP_ENTRY_W = $bits(warp_stack_entry_t);

    typedef enum logic [1:0] {
        RC_TAKEN,
        RC_ELSE,
        RC_RECONV
    } redirect_cause_e;

endpackage

// File: rtl/warp_lifo.sv
// Register-based LIFO with push, pop and in-place rewrite of the top entry; zero-latency top read.
// Push while full and pop while empty are ignored.
module warp_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    input  logic                       wr_top_i,
    input  logic [WIDTH-1:0]           top_wr_dat_i,
    output logic [WIDTH-1:0]           top_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    always_comb begin
        top_dat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) top_dat_o = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // slot i is the next free slot when count==i, and the top when count==i+1
                if (push_i && CW'(i) == count_q)
                    mem_q[i] <= push_dat_i;
                else if (wr_top_i && CW'(i + 1) == count_q)
                    mem_q[i] <= top_wr_dat_i;
            end
            if (push_i && !full_o)
                count_q <= count_q + 1'b1;
            else if (pop_i && !empty_o)
                count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/warp_mask_stack.sv
// Warp active-lane mask plus SIMT divergence/reconvergence stack; optional stats via WARP_MASK_STACK_STATS_EN.
// Results one cycle after the request; no backpressure, lower-priority requests in a cycle are dropped.
module warp_mask_stack
    import warp_pkg::*;
#(
    parameter int NUM_LANES   = 8,
    parameter int STACK_DEPTH = 4,
    parameter int PC_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mask_update,
    input  logic [NUM_LANES-1:0]               mask_in,
    input  logic                               branch_valid,
    input  logic [NUM_LANES-1:0]               branch_taken,
    input  logic [PC_WIDTH-1:0]                branch_target,
    input  logic [PC_WIDTH-1:0]                branch_fallthru,
    input  logic [PC_WIDTH-1:0]                branch_reconv,
    input  logic                               sync_valid,
    input  logic                               err_clr,
    output logic [NUM_LANES-1:0]               lane_enable,
    output logic [NUM_LANES-1:0]               mask_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               redirect_valid,
    output logic [PC_WIDTH-1:0]                redirect_pc,
    output logic                               overflow_err,
    output logic                               underflow_err
`ifdef WARP_MASK_STACK_STATS_EN
    ,
    output logic [31:0]                        div_count,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   max_depth,
    output logic [15:0]                        dropped_count
`endif
);

    localparam int DW = $clog2(STACK_DEPTH+1);

    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 rvld_q, rvld_d;
    logic [PC_WIDTH-1:0]  rpc_q, rpc_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 push, pop, wr_top;
    logic                 redir;
    redirect_cause_e      cause;
    warp_stack_entry_t    push_e, top_e, top_wr_e;
    logic [NUM_LANES-1:0] taken_act;

    warp_lifo #(
        .WIDTH (WARP_ENTRY_W),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_dat_i   (push_e),
        .pop_i        (pop),
        .wr_top_i     (wr_top),
        .top_wr_dat_i (top_wr_e),
        .top_dat_o    (top_e),
        .count_o      (depth),
        .empty_o      (stack_empty),
        .full_o       (stack_full)
    );

    assign taken_act = branch_taken & mask_q;

    always_comb begin
        mask_d   = mask_q;
        ovf_d    = ovf_q & ~err_clr;
        unf_d    = unf_q & ~err_clr;
        push     = 1'b0;
        pop      = 1'b0;
        wr_top   = 1'b0;
        redir    = 1'b0;
        cause    = RC_TAKEN;
        push_e   = '{rpc: branch_reconv, else_pc: branch_fallthru,
                     else_mask: mask_q & ~taken_act, orig_mask: mask_q, phase: 1'b0};
        top_wr_e = top_e;
        top_wr_e.phase = 1'b1;

        if (sync_valid) begin
            if (stack_empty) begin
                unf_d = 1'b1;
            end else if (!top_e.phase) begin
                mask_d = top_e.else_mask;
                wr_top = 1'b1;
                redir  = 1'b1;
                cause  = RC_ELSE;
            end else begin
                mask_d = top_e.orig_mask;
                pop    = 1'b1;
                redir  = 1'b1;
                cause  = RC_RECONV;
            end
        end else if (branch_valid) begin
            // uniform-taken is tested first so an all-zero mask still follows the taken path
            if (taken_act == mask_q) begin
                redir = 1'b1;
            end else if (taken_act != '0) begin
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push   = 1'b1;
                    mask_d = taken_act;
                    redir  = 1'b1;
                end
            end
        end else if (mask_update && stack_empty) begin
            mask_d = mask_in;
        end

        rvld_d = redir;
        rpc_d  = rpc_q;
        if (redir) begin
            unique case (cause)
                RC_ELSE:   rpc_d = top_e.else_pc;
                RC_RECONV: rpc_d = top_e.rpc;
                default:   rpc_d = branch_target;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
            rvld_q <= 1'b0;
            rpc_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            rvld_q <= rvld_d;
            rpc_q  <= rpc_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign lane_enable    = mask_q;
    assign mask_out       = mask_q;
    assign redirect_valid = rvld_q;
    assign redirect_pc    = rpc_q;
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;

`ifdef WARP_MASK_STACK_STATS_EN
    logic [31:0]   div_q, div_d;
    logic [DW-1:0] maxd_q, maxd_d;
    logic [15:0]   drop_q, drop_d;
    logic [1:0]    drop_n;
    logic [16:0]   drop_sum;

    always_comb begin
        drop_n = 2'd0;
        if (sync_valid)
            drop_n = 2'(branch_valid) + 2'(mask_update);
        else if (branch_valid)
            drop_n = 2'(mask_update);
        else if (mask_update && !stack_empty)
            drop_n = 2'd1;

        drop_sum = {1'b0, drop_q} + 17'(drop_n);
        drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
        div_d    = (push && div_q != '1) ? div_q + 1'b1 : div_q;
        maxd_d   = (push && (depth + 1'b1) > maxd_q) ? depth + 1'b1 : maxd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            maxd_q <= '0;
            drop_q <= '0;
        end else begin
            div_q  <= div_d;
            maxd_q <= maxd_d;
            drop_q <= drop_d;
        end
    end

    assign div_count     = div_q;
    assign max_depth     = maxd_q;
    assign dropped_count = drop_q;
`endif

endmodule

// File: tb/tb_warp_mask_stack.sv
// Scoreboarded bench for warp_mask_stack: expected outputs queued with each stimulus cycle, compared one cycle later.
module tb_warp_mask_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mask_update;
    logic [7:0]  mask_in;
    logic        branch_valid;
    logic [7:0]  branch_taken;
    logic [15:0] branch_target, branch_fallthru, branch_reconv;
    logic        sync_valid;
    logic        err_clr;
    logic [7:0]  lane_enable, mask_out;
    logic [2:0]  depth;
    logic        stack_empty, stack_full;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        overflow_err, underflow_err;
`ifdef WARP_MASK_STACK_STATS_EN
    logic [31:0] div_count;
    logic [2:0]  max_depth;
    logic [15:0] dropped_count;
`endif

    always #5 clk = ~clk;

    warp_mask_stack #(.NUM_LANES(8), .STACK_DEPTH(4), .PC_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mask_update     (mask_update),
        .mask_in         (mask_in),
        .branch_valid    (branch_valid),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .branch_fallthru (branch_fallthru),
        .branch_reconv   (branch_reconv),
        .sync_valid      (sync_valid),
        .err_clr         (err_clr),
        .lane_enable     (lane_enable),
        .mask_out        (mask_out),
        .depth           (depth),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
`ifdef WARP_MASK_STACK_STATS_EN
        ,
        .div_count       (div_count),
        .max_depth       (max_depth),
        .dropped_count   (dropped_count)
`endif
    );

    typedef struct {
        logic [7:0]  mask;
        logic [2:0]  depth;
        logic        rvld;
        logic [15:0] rpc;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ex(input logic [7:0] m, input logic [2:0] d, input logic rv,
                                input logic [15:0] pc, input logic ov, input logic un);
        exp_t e;
        e.mask = m; e.depth = d; e.rvld = rv; e.rpc = pc; e.ovf = ov; e.unf = un;
        return e;
    endfunction

    task automatic clear_inputs();
        mask_update = 1'b0; mask_in = '0;
        branch_valid = 1'b0; branch_taken = '0;
        branch_target = '0; branch_fallthru = '0; branch_reconv = '0;
        sync_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic set_branch(input logic [7:0] t, input logic [15:0] tgt,
                              input logic [15:0] fall, input logic [15:0] rec);
        branch_valid = 1'b1; branch_taken = t;
        branch_target = tgt; branch_fallthru = fall; branch_reconv = rec;
    endtask

    // Queue the expectation, advance one clock, then compare what the DUT produced.
    task automatic cycle(input string tag, input exp_t e);
        exp_t x;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            check({tag, ".mask"},  {24'd0, lane_enable}, {24'd0, x.mask});
            check({tag, ".mout"},  {24'd0, mask_out},    {24'd0, x.mask});
            check({tag, ".depth"}, {29'd0, depth},       {29'd0, x.depth});
            check({tag, ".empty"}, {31'd0, stack_empty}, {31'd0, (x.depth == 3'd0)});
            check({tag, ".full"},  {31'd0, stack_full},  {31'd0, (x.depth == 3'd4)});
            check({tag, ".rvld"},  {31'd0, redirect_valid}, {31'd0, x.rvld});
            if (x.rvld) check({tag, ".rpc"}, {16'd0, redirect_pc}, {16'd0, x.rpc});
            check({tag, ".ovf"},   {31'd0, overflow_err},  {31'd0, x.ovf});
            check({tag, ".unf"},   {31'd0, underflow_err}, {31'd0, x.unf});
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  nest_t [4];
        logic [7:0]  orig, else_m;
        logic [15:0] tgt;
        nest_t = '{8'h7F, 8'h3F, 8'h1F, 8'h0F};

        clear_inputs();
        rst_n = 1'b0;
        #12;
        check("rst.mask",  {24'd0, lane_enable}, 32'h0000_00FF);
        check("rst.depth", {29'd0, depth}, 32'd0);
        check("rst.rvld",  {31'd0, redirect_valid}, 32'd0);
        check("rst.rpc",   {16'd0, redirect_pc}, 32'd0);
        check("rst.errs",  {30'd0, overflow_err, underflow_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // uniform branches
        set_branch(8'hFF, 16'h0100, 16'h0104, 16'h0200);
        cycle("uni_taken", ex(8'hFF, 3'd0, 1'b1, 16'h0100, 1'b0, 1'b0));
        cycle("uni_idle",  ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0));
        set_branch(8'h00, 16'h0300, 16'h0304, 16'h0400);
        cycle("uni_not",   ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0));

        // single divergence and reconvergence
        set_branch(8'h0F, 16'h0100, 16'h0104, 16'h0200);
        cycle("div_push",  ex(8'h0F, 3'd1, 1'b1, 16'h0100, 1'b0, 1'b0));
        sync_valid = 1'b1;
        cycle("div_else",  ex(8'hF0, 3'd1, 1'b1, 16'h0104, 1'b0, 1'b0));
        sync_valid = 1'b1;
        cycle("div_pop",   ex(8'hFF, 3'd0, 1'b1, 16'h0200, 1'b0, 1'b0));

        // nest to full, then overflow
        for (int k = 0; k < 4; k++) begin
            tgt = 16'h0100 * 16'(k + 1);
            set_branch(nest_t[k], tgt, tgt + 16'h4, 16'h0800 + 16'(k));
            cycle("nest", ex(nest_t[k], 3'(k + 1), 1'b1, tgt, 1'b0, 1'b0));
        end
        set_branch(8'h03, 16'h0F00, 16'h0F04, 16'h0F08);
        cycle("ovf_set",   ex(8'h0F, 3'd4, 1'b0, 16'h0000, 1'b1, 1'b0));
        cycle("ovf_hold",  ex(8'h0F, 3'd4, 1'b0, 16'h0000, 1'b1, 1'b0));
        err_clr = 1'b1;
        cycle("ovf_clr",   ex(8'h0F, 3'd4, 1'b0, 16'h0000, 1'b0, 1'b0));

        // unwind all four levels
        for (int k = 3; k >= 0; k--) begin
            orig   = (k == 0) ? 8'hFF : nest_t[k-1];
            else_m = orig & ~nest_t[k];
            tgt    = 16'h0100 * 16'(k + 1);
            sync_valid = 1'b1;
            cycle("unw_else", ex(else_m, 3'(k + 1), 1'b1, tgt + 16'h4, 1'b0, 1'b0));
            sync_valid = 1'b1;
            cycle("unw_pop",  ex(orig, 3'(k), 1'b1, 16'h0800 + 16'(k), 1'b0, 1'b0));
        end

        // underflow; error event beats err_clr in the same cycle
        sync_valid = 1'b1;
        cycle("unf_set",   ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1));
        sync_valid = 1'b1; err_clr = 1'b1;
        cycle("unf_win",   ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1));
        err_clr = 1'b1;
        cycle("unf_clr",   ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0));

        // priority: sync wins over branch and mask_update
        set_branch(8'h0F, 16'h0100, 16'h0104, 16'h0200);
        cycle("pri_push",  ex(8'h0F, 3'd1, 1'b1, 16'h0100, 1'b0, 1'b0));
        sync_valid = 1'b1;
        set_branch(8'h03, 16'h0500, 16'h0504, 16'h0508);
        mask_update = 1'b1; mask_in = 8'h55;
        cycle("pri_sync",  ex(8'hF0, 3'd1, 1'b1, 16'h0104, 1'b0, 1'b0));
        mask_update = 1'b1; mask_in = 8'h55;
        cycle("mu_nonemp", ex(8'hF0, 3'd1, 1'b0, 16'h0000, 1'b0, 1'b0));
        sync_valid = 1'b1;
        cycle("pri_pop",   ex(8'hFF, 3'd0, 1'b1, 16'h0200, 1'b0, 1'b0));

        // mask_update when empty, then persists
        mask_update = 1'b1; mask_in = 8'hAA;
        cycle("mu_load",   ex(8'hAA, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++)
            cycle("mu_hold", ex(8'hAA, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0));

        // async reset mid-divergence
        set_branch(8'h0F, 16'h0600, 16'h0604, 16'h0608);
        cycle("mid_push",  ex(8'h0A, 3'd1, 1'b1, 16'h0600, 1'b0, 1'b0));
        rst_n = 1'b0;
        #2;
        check("mid_rst.mask",  {24'd0, lane_enable}, 32'h0000_00FF);
        check("mid_rst.depth", {29'd0, depth}, 32'd0);
        check("mid_rst.empty", {31'd0, stack_empty}, 32'd1);
        check("mid_rst.rvld",  {31'd0, redirect_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        sync_valid = 1'b1;
        cycle("post_rst",  ex(8'hFF, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
